oam_dma: RTL and testbench
==========================

// Module: oam_dma
// PURPOSE
//   Game Boy OAM DMA engine. A CPU write to the DMA register starts a copy of
//   LENGTH bytes from {page,8'h00} in work/cart RAM into OAM (FE00-FE9F).
//   It sits between the CPU register bus and the dual-port RAM:
//     - reads through the RAM's combinational read port;
//     - writes through the OAM write port.
//   busy tells the bus arbiter to lock the CPU out of non-HRAM memory.
// PARAMETERS
//   CYCLES_PER_BYTE  4         clocks per byte slot; legal range >= 2
//   LENGTH           160       bytes per transfer; legal range 1..256
//   REG_ADDR         16'hFF46  CPU address of the DMA register
// PORTS
//   clock        in   1   system clock, all state on posedge
//   reset_n      in   1   asynchronous, active-low reset
//   reg_addr     in   16  CPU bus address
//   reg_wr       in   1   CPU write strobe, 1-cycle pulse
//   reg_wdata    in   8   CPU write data (source page)
//   reg_rdata    out  8   DMA register readback (last written page)
//   src_addr     out  16  source RAM address (combinational-read port)
//   src_rd_data  in   8   source RAM data, valid same cycle as src_addr
//   oam_addr     out  8   OAM byte index 0..LENGTH-1
//   oam_wdata    out  8   OAM write data
//   oam_wr       out  1   OAM write enable, 1-cycle pulse per byte
//   busy         out  1   transfer in progress (start delay + copy)
// BEHAVIOUR
//   Reset (async, reset_n=0): all outputs take their reset values at once.
//     reg_rdata=8'h00, src_addr=16'h0000, oam_addr=0, oam_wdata=0,
//     oam_wr=0, busy=0. State goes to IDLE; slot counter and index go to 0.
//   Trigger: reg_wr && reg_addr==REG_ADDR, sampled at posedge T.
//     Latches page=reg_wdata and sets reg_rdata=reg_wdata from T+1.
//     Other addresses are ignored.
//   Page fold: if page>=8'hE0, the effective page is page & 8'hDF (echo RAM).
//     reg_rdata still returns the unfolded value.
//   All outputs are registered. The states are:
//   IDLE: busy=0, oam_wr=0. On trigger -> START, busy=1 from T+1.
//   START: waits CYCLES_PER_BYTE clocks, then goes to XFER with idx=0.
//     No memory activity.
//   XFER: each byte slot lasts CYCLES_PER_BYTE clocks.
//     - The whole slot: src_addr={eff_page, idx}.
//     - Slot cycle 0: src_rd_data is captured into the data register at its
//       closing edge.
//     - Slot cycle 1: oam_wr=1, oam_addr=idx, oam_wdata=captured byte.
//     - All other cycles: oam_wr=0.
//     - At the end of slot idx==LENGTH-1 -> IDLE.
//   busy timing: busy drops exactly CYCLES_PER_BYTE*(LENGTH+1) clocks after
//   T+1, i.e. 644 clocks at the defaults.
//   Retrigger while busy (START or XFER): restart from START with the new
//   page and idx=0.
//     - If the retrigger coincides with a slot cycle 1, that cycle's oam_wr
//       still completes.
//     - No further writes from the old transfer occur after that.
//   A trigger in the same cycle that busy would fall is a restart; busy stays
//   high with no gap.
//   The index is 8 bits and never wraps past LENGTH-1. The source low byte is
//   idx, so no page carry ever happens.
// TESTING
//   1. Write FF46=8'hC1 at the defaults -> busy high for 644 clocks.
//      Exactly 160 oam_wr pulses with oam_addr 0..159 in order.
//      Pulses are 4 clocks apart; each oam_wdata equals RAM[16'hC100+i].
//   2. Write FF46=8'hE3 -> src_addr runs 16'hC300..16'hC39F.
//      reg_rdata reads 8'hE3.
//   3. Write 8'hC0; at idx=50 write 8'hD0 -> OAM[0..49] holds C0xx data.
//      Then a 4-clock START, then a full 160-byte copy from 16'hD000.
//   4. Pulse reset_n low during XFER -> busy, oam_wr and reg_rdata are 0 the
//      same cycle, before any clock edge.
//      After release there is no activity until the next trigger.
//   5. reg_wr to 16'hFF47 while IDLE -> no busy, no oam_wr, reg_rdata
//      unchanged.
//   6. CYCLES_PER_BYTE=2, LENGTH=4, page 8'h80 -> busy for 10 clocks.
//      oam_wr pulses 2 clocks apart for idx 0..3.

Source files
------------

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to the DMA register copies LENGTH bytes from {page,8'h00}
// into OAM, one byte per CYCLES_PER_BYTE-clock slot, with busy held for the whole run.
module oam_dma #(
  parameter int          CYCLES_PER_BYTE = 4,
  parameter int          LENGTH          = 160,
  parameter logic [15:0] REG_ADDR        = 16'hFF46
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] reg_addr,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_rd_data,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_wr,
  output logic        busy
);

  localparam int CW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]    IDX_LAST = 8'(LENGTH - 1);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [7:0]      idx_reg, idx_next;
  logic [7:0]      page_reg, page_next;
  logic [15:0]     src_addr_reg, src_addr_next;
  logic [7:0]      oam_addr_reg, oam_addr_next;
  logic [7:0]      oam_wdata_reg, oam_wdata_next;
  logic            oam_wr_reg, oam_wr_next;
  logic            busy_reg, busy_next;
  logic            trig;
  logic [7:0]      eff_page;

  assign trig     = reg_wr && (reg_addr == REG_ADDR);
  // Echo RAM pages E0-FF alias C0-DF; only the source address sees the fold.
  assign eff_page = (page_reg >= 8'hE0) ? (page_reg & 8'hDF) : page_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= 8'h00;
      page_reg      <= 8'h00;
      src_addr_reg  <= 16'h0000;
      oam_addr_reg  <= 8'h00;
      oam_wdata_reg <= 8'h00;
      oam_wr_reg    <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      page_reg      <= page_next;
      src_addr_reg  <= src_addr_next;
      oam_addr_reg  <= oam_addr_next;
      oam_wdata_reg <= oam_wdata_next;
      oam_wr_reg    <= oam_wr_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    page_next      = page_reg;
    src_addr_next  = src_addr_reg;
    oam_addr_next  = oam_addr_reg;
    oam_wdata_next = oam_wdata_reg;
    oam_wr_next    = 1'b0;

    // A trigger always wins, which also kills any write the old transfer had pending.
    if (trig) begin
      page_next  = reg_wdata;
      state_next = START;
      cnt_next   = '0;
      idx_next   = 8'h00;
    end else begin
      case (state_reg)
        IDLE: ;
        START: begin
          if (cnt_reg == CNT_LAST) begin
            state_next    = XFER;
            cnt_next      = '0;
            idx_next      = 8'h00;
            src_addr_next = {eff_page, 8'h00};
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        XFER: begin
          if (cnt_reg == '0) begin
            oam_wr_next    = 1'b1;
            oam_addr_next  = idx_reg;
            oam_wdata_next = src_rd_data;
          end
          if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            if (idx_reg == IDX_LAST) begin
              state_next = IDLE;
            end else begin
              idx_next      = idx_reg + 8'd1;
              src_addr_next = {eff_page, idx_reg + 8'd1};
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  assign reg_rdata = page_reg;
  assign src_addr  = src_addr_reg;
  assign oam_addr  = oam_addr_reg;
  assign oam_wdata = oam_wdata_reg;
  assign oam_wr    = oam_wr_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: cycle-level reference model from the slot arithmetic, a transaction
// table, random triggers/retriggers, and hand sequences for reset and a small configuration.
module tb_oam_dma;

  localparam int CPB = 4;
  localparam int LEN = 160;
  localparam int TOT = CPB * (LEN + 1);

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] reg_addr;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic [15:0] src_addr;
  logic [7:0]  src_rd_data;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_wr;
  logic        busy;

  logic [15:0] s_reg_addr;
  logic        s_reg_wr;
  logic [7:0]  s_reg_wdata;
  logic [7:0]  s_reg_rdata;
  logic [15:0] s_src_addr;
  logic [7:0]  s_src_rd_data;
  logic [7:0]  s_oam_addr;
  logic [7:0]  s_oam_wdata;
  logic        s_oam_wr;
  logic        s_busy;

  logic [7:0] ram [65536];
  logic [7:0] oam_mem [256];

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int busy_cnt = 0;

  always #5 clock = ~clock;

  assign src_rd_data   = ram[src_addr];
  assign s_src_rd_data = ram[s_src_addr];

  oam_dma dut (
    .clock(clock), .reset_n(reset_n), .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .src_addr(src_addr),
    .src_rd_data(src_rd_data), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .oam_wr(oam_wr), .busy(busy)
  );

  oam_dma #(.CYCLES_PER_BYTE(2), .LENGTH(4)) dut_s (
    .clock(clock), .reset_n(reset_n), .reg_addr(s_reg_addr), .reg_wr(s_reg_wr),
    .reg_wdata(s_reg_wdata), .reg_rdata(s_reg_rdata), .src_addr(s_src_addr),
    .src_rd_data(s_src_rd_data), .oam_addr(s_oam_addr), .oam_wdata(s_oam_wdata),
    .oam_wr(s_oam_wr), .busy(s_busy)
  );

  function automatic logic [7:0] fold(input logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the last accepted trigger edge and page.
  int         cyc = 0;
  int         t0 = 0;
  bit         active = 1'b0;
  logic [7:0] m_page = 8'h00;
  logic [7:0] m_rdata = 8'h00;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active  <= 1'b0;
      m_rdata <= 8'h00;
    end else begin
      cyc <= cyc + 1;
      if (reg_wr && reg_addr == 16'hFF46) begin
        t0      <= cyc + 1;
        m_page  <= reg_wdata;
        m_rdata <= reg_wdata;
        active  <= 1'b1;
      end
    end
  end

  always @(negedge clock) begin : chk
    int         k;
    logic       eb, ew;
    logic [7:0] ix, ep;
    k  = cyc - t0;
    ep = fold(m_page);
    eb = active && (k < TOT);
    ew = eb && (k >= CPB) && ((k % CPB) == 1);
    ix = 8'(k / CPB - 1);
    check("busy", 32'(busy), 32'(eb));
    check("oam_wr", 32'(oam_wr), 32'(ew));
    check("reg_rdata", 32'(reg_rdata), 32'(m_rdata));
    if (ew) begin
      check("oam_addr", 32'(oam_addr), 32'(ix));
      check("oam_wdata", 32'(oam_wdata), 32'(ram[{ep, ix}]));
    end
    if (eb && k >= CPB) check("src_addr", 32'(src_addr), 32'({ep, ix}));
    if (oam_wr) begin
      pulses++;
      oam_mem[oam_addr] = oam_wdata;
    end
    if (busy) busy_cnt++;
  end

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_wr    = 1'b1;
    @(posedge clock);
    #1;
    reg_wr = 1'b0;
  endtask

  task automatic do_write_s(input logic [15:0] a, input logic [7:0] d);
    s_reg_addr  = a;
    s_reg_wdata = d;
    s_reg_wr    = 1'b1;
    @(posedge clock);
    #1;
    s_reg_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_oam(input string nm, input logic [7:0] page, input int cnt);
    int bad;
    bad = -1;
    for (int i = cnt - 1; i >= 0; i--)
      if (oam_mem[i] !== ram[{fold(page), 8'(i)}]) bad = i;
    check(nm, 32'(bad), 32'hFFFF_FFFF);
  endtask

  task automatic clear_obs();
    pulses   = 0;
    busy_cnt = 0;
    for (int i = 0; i < 256; i++) oam_mem[i] = 8'hxx;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_busy;
    logic [7:0]  exp_rdata;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [6];
    logic [7:0] p;
    int n;
    vecs[0] = '{16'hFF47, 8'h55, 1'b0, 8'h00};
    vecs[1] = '{16'hFF46, 8'hC1, 1'b1, 8'hC1};
    vecs[2] = '{16'hFF46, 8'hE3, 1'b1, 8'hE3};
    vecs[3] = '{16'hFF45, 8'h12, 1'b0, 8'hE3};
    vecs[4] = '{16'hFF46, 8'hFF, 1'b1, 8'hFF};
    vecs[5] = '{16'hFF46, 8'h00, 1'b1, 8'h00};

    reset_n = 1'b0;
    reg_addr = 16'h0000; reg_wr = 1'b0; reg_wdata = 8'h00;
    s_reg_addr = 16'h0000; s_reg_wr = 1'b0; s_reg_wdata = 8'h00;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", 32'(reg_rdata), 32'd0);
    check("rst_src_addr", 32'(src_addr), 32'd0);
    check("rst_oam_addr", 32'(oam_addr), 32'd0);
    check("rst_oam_wdata", 32'(oam_wdata), 32'd0);
    check("rst_oam_wr", 32'(oam_wr), 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Table: register writes, with whole-transfer results checked afterwards.
    for (int v = 0; v < 6; v++) begin
      clear_obs();
      do_write(vecs[v].addr, vecs[v].data);
      repeat (2) @(posedge clock);
      #1;
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
      check($sformatf("vec%0d_rdata", v), 32'(reg_rdata), 32'(vecs[v].exp_rdata));
      wait_idle();
      if (vecs[v].exp_busy) begin
        check($sformatf("vec%0d_pulses", v), 32'(pulses), 32'(LEN));
        check($sformatf("vec%0d_busy_len", v), 32'(busy_cnt), 32'(TOT));
        check_oam($sformatf("vec%0d_oam", v), vecs[v].data, LEN);
      end else begin
        check($sformatf("vec%0d_pulses", v), 32'(pulses), 32'd0);
        check($sformatf("vec%0d_busy_len", v), 32'(busy_cnt), 32'd0);
      end
      $display("vec %0d addr=%h data=%h pulses=%0d busy_cycles=%0d", v, vecs[v].addr,
               vecs[v].data, pulses, busy_cnt);
    end

    // Retrigger on the idx 50 write cycle.
    clear_obs();
    do_write(16'hFF46, 8'hC0);
    n = 0;
    while (!(oam_wr === 1'b1 && oam_addr === 8'd50) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("idx50_seen", 32'(n < 1000), 32'd1);
    do_write(16'hFF46, 8'hD0);
    check("retrig_old_pulses", 32'(pulses), 32'd51);
    check_oam("retrig_old_oam", 8'hC0, 51);
    wait_idle();
    check("retrig_total_pulses", 32'(pulses), 32'd211);
    check_oam("retrig_new_oam", 8'hD0, LEN);
    $display("retrigger C0->D0 pulses=%0d", pulses);

    // Trigger on the exact edge busy would fall: no gap.
    clear_obs();
    do_write(16'hFF46, 8'hC2);
    repeat (TOT - 1) @(posedge clock);
    #1;
    do_write(16'hFF46, 8'h9A);
    wait_idle();
    check("b2b_busy_len", 32'(busy_cnt), 32'(2 * TOT));
    check("b2b_pulses", 32'(pulses), 32'(2 * LEN));
    $display("back-to-back busy_cycles=%0d pulses=%0d", busy_cnt, pulses);

    // Random triggers at random spacing, many of them retriggers.
    for (int it = 0; it < 8; it++) begin
      p = 8'($urandom);
      do_write(16'hFF46, p);
      $display("random trigger %0d page=%h", it, p);
      repeat ($urandom_range(0, 700)) @(posedge clock);
      #1;
    end
    clear_obs();
    do_write(16'hFF46, 8'($urandom_range(8'hE0, 8'hFF)));
    p = reg_wdata;
    wait_idle();
    check_oam("random_final_oam", p, LEN);

    // Asynchronous reset while a write pulse is on the bus.
    do_write(16'hFF46, 8'hC5);
    n = 0;
    while (!(oam_wr === 1'b1 && oam_addr >= 8'd10) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("reset_wr_seen", 32'(n < 1000), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_oam_wr", 32'(oam_wr), 32'd0);
    check("async_rdata", 32'(reg_rdata), 32'd0);
    check("async_src_addr", 32'(src_addr), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    clear_obs();
    repeat (30) @(posedge clock);
    #1;
    check("post_reset_pulses", 32'(pulses), 32'd0);
    check("post_reset_busy", 32'(busy_cnt), 32'd0);
    $display("async reset mid-transfer, quiet afterwards pulses=%0d", pulses);

    // Small configuration: 2 clocks per byte, 4 bytes.
    do_write_s(16'hFF46, 8'h80);
    n = 0;
    for (int k = 0; k < 14; k++) begin
      logic ew;
      @(negedge clock);
      ew = (k >= 2) && (k < 10) && (k % 2 == 1);
      check($sformatf("small_busy_k%0d", k), 32'(s_busy), 32'(k < 10));
      check($sformatf("small_wr_k%0d", k), 32'(s_oam_wr), 32'(ew));
      if (ew) begin
        check("small_oam_addr", 32'(s_oam_addr), 32'(n));
        check("small_oam_wdata", 32'(s_oam_wdata), 32'(ram[16'h8000 + n]));
        n++;
      end
    end
    check("small_rdata", 32'(s_reg_rdata), 32'h80);
    $display("small config page=80 writes=%0d", n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
